// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared widths, state and owner encodings for mem_port_arbiter
package mem_port_arbiter_pkg;

  localparam int ISIZE = 32;
  localparam int DSIZE = 32;

  typedef enum logic {
    MA_IDLE   = 1'b0,
    MA_ACCESS = 1'b1
  } ma_state_e;

  typedef enum logic {
    MA_OWN_IF = 1'b0,
    MA_OWN_DM = 1'b1
  } ma_owner_e;

endpackage

// File: rtl/mem_lat_timer.sv
// rtl/mem_lat_timer.sv - access cycle counter; done when the count reaches MEM_LAT
module mem_lat_timer #(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       step_i,
  output logic [3:0] cnt_o,
  output logic       done_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = 4'd0;
    end else if (step_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == MEM_LAT[3:0]);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch (IF) and data (DM) requesters
// Optional IF anti-starvation counter enabled by defining MEMARB_STARVE_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [ISIZE-1:0] if_addr,
  output logic             if_ready,
  output logic [DSIZE-1:0] if_rdata,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [ISIZE-1:0] dm_addr,
  input  logic [DSIZE-1:0] dm_wdata,
  output logic             dm_ready,
  output logic [DSIZE-1:0] dm_rdata,
  output logic             mem_en,
  output logic             mem_wen,
  output logic [ISIZE-1:0] mem_addr,
  output logic [DSIZE-1:0] mem_wdata,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic             stall_if,
  output logic             stall_mem,
  output logic             busy
);

  ma_state_e        state_q;
  ma_owner_e        owner_q;
  logic [ISIZE-1:0] addr_q;
  logic             we_q;
  logic [DSIZE-1:0] wdata_q;
  logic [3:0]       cnt;
  logic             cnt_done;
  logic             in_access;
  logic             first_beat;
  logic             done;
  logic             grant_dm;

  assign in_access  = (state_q == MA_ACCESS);
  assign first_beat = in_access && (cnt == 4'd0);
  // Writes finish on the strobe cycle; reads wait out the memory latency.
  assign done       = in_access && (we_q ? (cnt == 4'd0) : cnt_done);

  mem_lat_timer #(
    .MEM_LAT(MEM_LAT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start_i(!in_access),
    .step_i (in_access && !done),
    .cnt_o  (cnt),
    .done_o (cnt_done)
  );

`ifdef MEMARB_STARVE_EN
  logic [3:0] starve_q;
  logic [3:0] starve_d;

  assign grant_dm = dm_req && !(if_req && (starve_q == STARVE_MAX[3:0]));

  always_comb begin
    starve_d = starve_q;
    if (!in_access && (if_req || dm_req)) begin
      if (!grant_dm) begin
        starve_d = 4'd0;
      end else if (if_req) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign grant_dm = dm_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MA_IDLE;
      owner_q <= MA_OWN_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        MA_IDLE: begin
          if (if_req || dm_req) begin
            state_q <= MA_ACCESS;
            owner_q <= grant_dm ? MA_OWN_DM : MA_OWN_IF;
            addr_q  <= grant_dm ? dm_addr : if_addr;
            we_q    <= grant_dm && dm_we;
            wdata_q <= dm_wdata;
          end
        end
        default: begin
          if (done) begin
            state_q <= MA_IDLE;
          end
        end
      endcase
    end
  end

  assign mem_en    = first_beat;
  assign mem_wen   = first_beat && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_ready  = done && (owner_q == MA_OWN_IF);
  assign dm_ready  = done && (owner_q == MA_OWN_DM);
  assign if_rdata  = if_ready ? mem_rdata : '0;
  assign dm_rdata  = (dm_ready && !we_q) ? mem_rdata : '0;

  assign stall_if  = if_req && !if_ready;
  assign stall_mem = dm_req && !dm_ready;
  assign busy      = in_access;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - bench for mem_port_arbiter against a transaction-level model (MEMARB_STARVE_EN aware)
module tb_mem_port_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MEM_LAT(LAT),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'h1000_0000 | i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Fixed-latency memory: read data appears LAT cycles after the strobe, junk otherwise.
  logic [31:0] mem_arr [64];
  bit   [63:0] mem_wr;
  logic [31:0] st_d [LAT];
  bit          st_v [LAT];
  logic [31:0] junk;
  logic [5:0]  mem_idx;

  assign mem_idx   = mem_addr[5:0];
  assign mem_rdata = st_v[LAT-1] ? st_d[LAT-1] : junk;

  always @(posedge clk) begin
    junk <= $urandom;
    if (mem_en && mem_wen) begin
      mem_arr[mem_idx] <= mem_wdata;
      mem_wr[mem_idx]  <= 1'b1;
    end
    st_v[0] <= mem_en && !mem_wen;
    st_d[0] <= mem_wr[mem_idx] ? mem_arr[mem_idx] : init_word(int'(mem_idx));
    for (int i = 1; i < LAT; i++) begin
      st_v[i] <= st_v[i-1];
      st_d[i] <= st_d[i-1];
    end
  end

  // Transaction-level model: one access at a time, k = cycles since it was granted.
  bit          m_act;
  bit          m_dm;
  bit          m_we;
  bit          g_dm;
  int          m_k;
  int          m_starve;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] shadow [64];
  bit          e_en, e_done, e_ifr, e_dmr;
  logic [31:0] e_ifd, e_dmd;

  initial begin
    for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
    m_act = 0;
    m_starve = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_act = 0;
        m_starve = 0;
      end
      e_en   = m_act && (m_k == 0);
      e_done = m_act && (m_we ? (m_k == 0) : (m_k == LAT));
      e_ifr  = e_done && !m_dm;
      e_dmr  = e_done && m_dm;
      e_ifd  = e_ifr ? shadow[m_addr[5:0]] : 32'h0;
      e_dmd  = (e_dmr && !m_we) ? shadow[m_addr[5:0]] : 32'h0;
      chk("m_busy", busy, m_act);
      chk("m_mem_en", mem_en, e_en);
      chk("m_if_ready", if_ready, e_ifr);
      chk("m_dm_ready", dm_ready, e_dmr);
      chk("m_if_rdata", if_rdata, e_ifd);
      chk("m_dm_rdata", dm_rdata, e_dmd);
      chk("m_stall_if", stall_if, if_req && !e_ifr);
      chk("m_stall_mem", stall_mem, dm_req && !e_dmr);
      if (m_act) chk("m_mem_addr", mem_addr, m_addr);
      if (e_en) begin
        chk("m_mem_wen", mem_wen, m_we);
        if (m_we) chk("m_mem_wdata", mem_wdata, m_wdata);
      end
      if (!rst) begin
        chk("m_rst_addr", mem_addr, 32'h0);
        chk("m_rst_wdata", mem_wdata, 32'h0);
      end else if (m_act) begin
        if (e_done) begin
          if (m_we) shadow[m_addr[5:0]] = m_wdata;
          m_act = 0;
        end else begin
          m_k++;
        end
      end else if (if_req || dm_req) begin
        g_dm = dm_req;
`ifdef MEMARB_STARVE_EN
        if (dm_req && if_req && m_starve == SMAX) g_dm = 0;
        if (!g_dm) m_starve = 0;
        else if (if_req) m_starve++;
`endif
        m_act   = 1;
        m_k     = 0;
        m_dm    = g_dm;
        m_addr  = g_dm ? dm_addr : if_addr;
        m_we    = g_dm ? dm_we : 1'b0;
        m_wdata = dm_wdata;
      end
    end
  end

  initial begin
    bit ord [6];
    bit exp_ord [6];
    int n;
    bit ifr, dmr;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 32'h0);
    chk("rst_mem_en", mem_en, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_readies", {dm_ready, if_ready}, 32'h0);
    @(posedge clk); #1 rst = 1'b1;

    // IF read of 0x10
    @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk); chk("if_c0_stall", stall_if, 1); chk("if_c0_en", mem_en, 0);
    @(negedge clk); chk("if_c1_en", mem_en, 1); chk("if_c1_addr", mem_addr, 32'h10);
    @(negedge clk); chk("if_c2_stall", stall_if, 1); chk("if_c2_ready", if_ready, 0);
    @(negedge clk); chk("if_c3_ready", if_ready, 1); chk("if_c3_rdata", if_rdata, 32'h1000_0010);
    chk("if_c3_stall", stall_if, 0);
    @(posedge clk); #1 if_req = 1'b0;

    // DM write of DEADBEEF to 0x8
    @(posedge clk); #1 dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h8; dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk); chk("wr_c0_busy", busy, 0);
    @(negedge clk); chk("wr_c1_en", mem_en, 1); chk("wr_c1_wen", mem_wen, 1);
    chk("wr_c1_ready", dm_ready, 1); chk("wr_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("wr_c1_rdata", dm_rdata, 0);
    @(posedge clk); #1 dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk); chk("wr_c2_busy", busy, 0);

    // Contention: DM read 0x20 wins, IF read 0x30 follows
    @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h30; dm_req = 1'b1; dm_addr = 32'h20;
    @(negedge clk);
    @(negedge clk); chk("ct_c1_addr", mem_addr, 32'h20);
    @(negedge clk);
    @(negedge clk); chk("ct_c3_dmready", dm_ready, 1); chk("ct_c3_dmrdata", dm_rdata, 32'h1000_0020);
    chk("ct_c3_ifready", if_ready, 0);
    @(posedge clk); #1 dm_req = 1'b0;
    @(negedge clk); chk("ct_c4_stall_if", stall_if, 1);
    @(negedge clk); chk("ct_c5_en", mem_en, 1); chk("ct_c5_addr", mem_addr, 32'h30);
    @(negedge clk);
    @(negedge clk); chk("ct_c7_ifready", if_ready, 1); chk("ct_c7_ifrdata", if_rdata, 32'h1000_0030);
    @(posedge clk); #1 if_req = 1'b0;

    // DM read-back of the earlier write
    @(posedge clk); #1 dm_req = 1'b1; dm_addr = 32'h8;
    repeat (4) @(negedge clk);
    chk("rb_ready", dm_ready, 1); chk("rb_rdata", dm_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1 dm_req = 1'b0;

    // Reset in the middle of a DM read
    @(posedge clk); #1 dm_req = 1'b1; dm_addr = 32'h4;
    @(negedge clk);
    @(negedge clk); chk("ra_c1_en", mem_en, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("ra_c2_en", mem_en, 0); chk("ra_c2_busy", busy, 0);
    chk("ra_c2_ready", dm_ready, 0); chk("ra_c2_stall", stall_mem, 1);
    @(negedge clk); chk("ra_c3_ready", dm_ready, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); chk("ra_c4_busy", busy, 0);
    @(negedge clk); chk("ra_c5_en", mem_en, 1); chk("ra_c5_addr", mem_addr, 32'h4);
    @(negedge clk); chk("ra_c6_ready", dm_ready, 0);
    @(negedge clk); chk("ra_c7_ready", dm_ready, 1); chk("ra_c7_rdata", dm_rdata, 32'h1000_0004);
    @(posedge clk); #1 dm_req = 1'b0;

    // Both requesters held continuously: grant order
    @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h3C; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2C;
    n = 0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      @(negedge clk);
      if (dm_ready) begin ord[n] = 1; n++; end
      else if (if_ready) begin ord[n] = 0; n++; end
    end
    chk("grant_count", n, 6);
`ifdef MEMARB_STARVE_EN
    exp_ord = '{1, 1, 0, 1, 1, 0};
`else
    exp_ord = '{1, 1, 1, 1, 1, 1};
`endif
    for (int i = 0; i < 6; i++) chk($sformatf("grant_%0d_is_dm", i), ord[i], exp_ord[i]);
    @(posedge clk); #1 if_req = 1'b0; dm_req = 1'b0;
    @(posedge clk);

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ifr = if_ready;
      dmr = dm_ready;
      @(posedge clk); #1;
      if (!if_req || ifr) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = $urandom_range(0, 63);
      end else if ($urandom_range(0, 7) == 0) begin
        if_addr = $urandom_range(0, 63);
      end
      if (!dm_req || dmr) begin
        dm_req   = ($urandom_range(0, 2) != 0);
        dm_we    = ($urandom_range(0, 2) == 0);
        dm_addr  = $urandom_range(0, 63);
        dm_wdata = $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        dm_addr  = $urandom_range(0, 63);
        dm_wdata = $urandom;
      end
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 249) == 0) rst = 1'b0;
    end
    rst = 1'b1;
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
